// File: rtl/alu_serial_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_engine_if
//  Description : Handshake and operand/result bundle between a control unit
//                (master) and the bit-serial ALU engine (slave).
//                  start, alu_op, a, b         master -> engine
//                  busy, done, result, zero,
//                  overflow, carry_out         engine -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_serial_engine_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output start, alu_op, a, b,
        input  busy, done, result, zero, overflow, carry_out
    );

    modport slave (
        input  start, alu_op, a, b,
        output busy, done, result, zero, overflow, carry_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_serial_engine.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_engine
//  Description : Bit-serial ALU. Processes one bit-slice per clock
//                (AND / OR / ADD / LESS) with the ripple carry held in a flop,
//                then assembles the word and its flags.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    alu_serial_engine_if.slave
//                       start/alu_op/a/b in; busy/done/result/zero/
//                       overflow/carry_out out
//  Revision    : 1.0  initial release
// ============================================================================
module alu_serial_engine #(
    parameter int WIDTH = 24
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_serial_engine_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] c_SEL_AND  = 2'b00;
    localparam logic [1:0] c_SEL_OR   = 2'b01;
    localparam logic [1:0] c_SEL_ADD  = 2'b10;

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CNT_W-1:0] r_idx;
    // Holds slices 0..WIDTH-2; the MSB slice is merged in directly on the
    // final edge, so one fewer flop than the word width is needed.
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;

    logic             w_ai;
    logic             w_bi;
    logic             w_sum;
    logic             w_cnext;
    logic             w_ri;
    logic             w_arith;
    logic             w_last;
    logic             w_ovf;
    logic             w_set;
    logic [WIDTH-2:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;

    // ------------------------------------------------------------------
    // Current bit-slice
    // ------------------------------------------------------------------
    always_comb begin
        w_ai    = r_a[r_idx];
        w_bi    = r_b[r_idx] ^ r_op[2];
        w_sum   = w_ai ^ w_bi ^ r_carry;
        w_cnext = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
        w_arith = r_op[1];
        w_last  = (r_idx == c_LAST_IDX);
        // Only meaningful on the MSB slice: r_carry is the carry into it.
        w_ovf   = r_carry ^ w_cnext;
        w_set   = w_sum ^ w_ovf;

        case (r_op[1:0])
            c_SEL_AND: w_ri = w_ai & w_bi;
            c_SEL_OR:  w_ri = w_ai | w_bi;
            c_SEL_ADD: w_ri = w_sum;
            default:   w_ri = 1'b0;   // LESS word is built from w_set
        endcase
    end

    generate
        if (WIDTH > 2) begin : g_shift_wide
            assign w_shift_nxt = {w_ri, r_shift[WIDTH-2:1]};
        end else begin : g_shift_narrow
            assign w_shift_nxt = w_ri;
        end
    endgenerate

    always_comb begin
        if (r_op[1:0] == 2'b11) begin
            w_word = {{(WIDTH-1){1'b0}}, w_set};
        end else begin
            w_word = {w_ri, r_shift};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.alu_op;
                        // bnegate doubles as the carry-in for subtraction
                        r_carry <= bus.alu_op[2];
                        r_idx   <= '0;
                        r_shift <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_shift <= w_shift_nxt;
                    r_idx   <= r_idx + CNT_W'(1);
                    if (w_arith) begin
                        r_carry <= w_cnext;
                    end
                    if (w_last) begin
                        r_result <= w_word;
                        r_zero   <= (w_word == '0);
                        r_ovf    <= w_arith & w_ovf;
                        r_cout   <= w_arith & w_cnext;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.carry_out = r_cout;

endmodule
`default_nettype wire
